// File: rtl/enable_pulse_gen_pkg.sv
// enable_pulse_gen_pkg: shared state encoding and default widths for the enable pulse generator
package enable_pulse_gen_pkg;
  localparam int DEF_DIV_W   = 8;
  localparam int DEF_BURST_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/enable_pulse_gen_prescaler.sv
// enable_prescaler: loadable down-counter that reloads on zero and flags tick while at zero
//   clk, rst_n       clock, asynchronous active-low reset
//   load_i           force counter to load_val_i (wins over run_i)
//   load_val_i       value used for explicit loads and for reload-on-zero
//   run_i            count down / reload while high, hold while low
//   tick_o           counter is zero (registered decode)
module enable_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == '0;
  always_comb cnt_d = (load_i || (run_i && tick_o)) ? load_val_i :
                      run_i ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: programmable-period enable strobe generator with optional finite burst
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i, stop_i  run control, sampled each edge; stop always wins
//   div_i            enable period in cycles (0 treated as 1), latched at start
//   burst_len_i      enables per run (0 = continuous), latched at start
//   enable_o         single-cycle strobe to the downstream counter
//   busy_o           high while running
//   done_o           single-cycle pulse after a burst completes (not after stop)
//   pulse_cnt_o      enables issued in the current / last run
// Optional macro ENABLE_PULSE_GEN_RETRIGGER_EN: start while running restarts the run.
module enable_pulse_gen
  import enable_pulse_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               enable_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [BURST_W-1:0] pulse_cnt_o
);
  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, div_eff, load_val;
  logic [BURST_W-1:0] burst_q, burst_d, cnt_q, cnt_d;
  logic               load, tick, last;

  assign div_eff     = div_i == '0 ? DIV_W'(1) : div_i;
  // explicit loads take the fresh input period, reload-on-zero the latched one
  assign load_val    = load ? div_eff - DIV_W'(1) : div_q - DIV_W'(1);
  assign busy_o      = state_q == RUN;
  assign enable_o    = busy_o && tick;
  assign done_o      = state_q == DONE;
  assign pulse_cnt_o = cnt_q;
  assign last        = burst_q != '0 && cnt_q == burst_q - BURST_W'(1);

  enable_prescaler #(.W(DIV_W)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .load_val_i(load_val),
    .run_i     (busy_o),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    burst_d = burst_q;
    cnt_d   = enable_o ? cnt_q + BURST_W'(1) : cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start_i && !stop_i) begin
        state_d = RUN;
        load    = 1'b1;
        div_d   = div_eff;
        burst_d = burst_len_i;
        cnt_d   = '0;
      end
      RUN: if (stop_i) state_d = IDLE;
`ifdef ENABLE_PULSE_GEN_RETRIGGER_EN
      // restart: a strobe issued this cycle is not credited to the new run
      else if (start_i) begin
        load    = 1'b1;
        div_d   = div_eff;
        burst_d = burst_len_i;
        cnt_d   = '0;
      end
`endif
      else if (enable_o && last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(1);
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: directed scenarios plus random stimulus against a cycle-count reference model
module tb_enable_pulse_gen;
  logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [7:0] div_i = '0, burst_len_i = '0;
  logic       enable_o, busy_o, done_o;
  logic [7:0] pulse_cnt_o;
  int total = 0, bad = 0, en_seen = 0;
  bit m_busy = 0, m_done = 0;
  int m_k = 0, m_div = 1, m_burst = 0, m_cnt = 0;

  enable_pulse_gen #(.DIV_W(8), .BURST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .div_i(div_i), .burst_len_i(burst_len_i), .enable_o(enable_o),
    .busy_o(busy_o), .done_o(done_o), .pulse_cnt_o(pulse_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: m_k counts cycles since the run began (1 = first busy cycle);
  // enables fall on every multiple of the period
  function automatic bit exp_en();
    return m_busy && (m_k % m_div == 0);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_k = 0; m_div = 1; m_burst = 0; m_cnt = 0;
  endtask

  task automatic step(bit st, bit sp, int dv, int bl);
    bit en;
    @(negedge clk);
    en = exp_en();
    chk("enable", enable_o, en);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    chk("pulse_cnt", pulse_cnt_o, m_cnt);
    if (enable_o) en_seen++;
    start_i = st; stop_i = sp; div_i = 8'(dv); burst_len_i = 8'(bl);
    if (m_busy) begin
      if (sp) begin
        m_busy = 0; m_cnt = (m_cnt + en) % 256;
      end
`ifdef ENABLE_PULSE_GEN_RETRIGGER_EN
      else if (st) begin
        m_k = 1; m_div = dv == 0 ? 1 : dv; m_burst = bl; m_cnt = 0;
      end
`endif
      else if (m_burst != 0 && en && m_cnt + 1 == m_burst) begin
        m_busy = 0; m_done = 1; m_cnt = m_cnt + 1;
      end else begin
        m_k++; m_cnt = (m_cnt + en) % 256;
      end
    end else if (m_done) m_done = 0;
    else if (st && !sp) begin
      m_busy = 1; m_k = 1; m_div = dv == 0 ? 1 : dv; m_burst = bl; m_cnt = 0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0; start_i = 0; stop_i = 0;
    #1;
    chk("rst_enable", enable_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt", pulse_cnt_o, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("por_enable", enable_o, 0);
    chk("por_busy", busy_o, 0);
    chk("por_cnt", pulse_cnt_o, 0);
    #16 rst_n = 1'b1;
    // burst of 3 at period 4
    en_seen = 0;
    step(1, 0, 4, 3); idle(15);
    chk("t1_cnt", pulse_cnt_o, 3);
    chk("t1_enables", en_seen, 3);
    // period 0 behaves as 1
    step(1, 0, 0, 5); idle(8);
    chk("t2_cnt", pulse_cnt_o, 5);
    // continuous run stopped after second enable
    step(1, 0, 4, 0); idle(7); step(0, 1, 4, 0); idle(4);
    chk("t3_cnt", pulse_cnt_o, 2);
    // async reset in the middle of a run
    step(1, 0, 2, 0); idle(4); async_reset(); idle(5);
    // period change during run ignored, then start&stop together
    step(1, 0, 3, 0); step(0, 0, 3, 0); step(0, 0, 7, 9); idle(9); step(0, 1, 7, 0); idle(2);
    step(1, 1, 4, 2); idle(3);
    // start again mid-run
    step(1, 0, 4, 3); idle(4); step(1, 0, 4, 3); idle(16);
    // continuous wrap of the pulse counter
    step(1, 0, 1, 0); idle(300); step(0, 1, 1, 0); idle(2);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 350) async_reset();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 5), $urandom_range(0, 6));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
